distance_filter_alarm: RTL



---
 rtl/distance_filter_alarm.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/distance_filter_alarm.sv
// Zero-rejecting moving-average filter with hysteretic proximity and no-echo flags.
// Optional median-of-3 prefilter: define DIST_MEDIAN3_EN.
module distance_filter_alarm #(
  parameter int          PERIOD_W   = 21,
  parameter int          AVG_LOG2   = 2,
  parameter logic [11:0] NEAR_TH    = 12'd30,
  parameter logic [11:0] HYST       = 12'd5,
  parameter logic [3:0]  ZERO_LIMIT = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] distance,
  input  logic        clear,
  output logic [11:0] avg_distance,
  output logic        avg_valid,
  output logic        near,
  output logic        no_echo
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [11:0] FAR_TH = NEAR_TH + HYST;

  typedef enum logic {FAR, NEAR} prox_e;

  logic [PERIOD_W-1:0] per_q;
  logic [11:0]         last_q;
  logic [3:0]          zcnt_q, zcnt_d;
  logic                strobe, acc;
  logic                s1_vld_q;
  logic [11:0]         s1_dat_q;
  logic                wr_vld;
  logic [11:0]         wr_dat;
  logic [11:0]         win_q [DEPTH];
  logic [AVG_LOG2-1:0] ptr_q;
  logic [SW-1:0]       sum_q, sum_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [11:0]         avg_q;
  logic                avg_vld_q;
  logic                no_echo_q;
  prox_e               prox_q, prox_d;

  assign strobe = (distance != last_q) || (&per_q);
  assign acc    = strobe && !clear && (distance != 12'd0);

  always_comb begin
    zcnt_d = zcnt_q;
    if (strobe) begin
      if (distance == 12'd0) begin
        if (zcnt_q != ZERO_LIMIT) zcnt_d = zcnt_q + 4'd1;
      end else begin
        zcnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q     <= '0;
      last_q    <= '0;
      zcnt_q    <= '0;
      no_echo_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
    end else begin
      per_q    <= per_q + PERIOD_W'(1);
      s1_dat_q <= distance;
      if (strobe) last_q <= distance;
      if (clear) begin
        zcnt_q    <= '0;
        no_echo_q <= 1'b0;
        s1_vld_q  <= 1'b0;
      end else begin
        zcnt_q    <= zcnt_d;
        no_echo_q <= (zcnt_d == ZERO_LIMIT);
        s1_vld_q  <= acc;
      end
    end
  end

`ifdef DIST_MEDIAN3_EN
  logic [11:0] h0_q, h1_q, med, m_dat_q;
  logic [1:0]  hcnt_q;
  logic        m_vld_q;

  always_comb begin
    med = s1_dat_q;
    if (s1_dat_q > h0_q) begin
      if (h0_q > h1_q)          med = h0_q;
      else if (s1_dat_q > h1_q) med = h1_q;
      else                      med = s1_dat_q;
    end else begin
      if (s1_dat_q > h1_q)  med = s1_dat_q;
      else if (h0_q > h1_q) med = h1_q;
      else                  med = h0_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q    <= '0;
      h1_q    <= '0;
      hcnt_q  <= '0;
      m_vld_q <= 1'b0;
      m_dat_q <= '0;
    end else if (clear) begin
      h0_q    <= '0;
      h1_q    <= '0;
      hcnt_q  <= '0;
      m_vld_q <= 1'b0;
    end else begin
      m_vld_q <= s1_vld_q && (hcnt_q == 2'd2);
      m_dat_q <= med;
      if (s1_vld_q) begin
        h1_q <= h0_q;
        h0_q <= s1_dat_q;
        if (hcnt_q != 2'd2) hcnt_q <= hcnt_q + 2'd1;
      end
    end
  end

  assign wr_vld = m_vld_q;
  assign wr_dat = m_dat_q;
`else
  assign wr_vld = s1_vld_q;
  assign wr_dat = s1_dat_q;
`endif

  // Unfilled slots hold zero, so warm-up needs no special case in the sum.
  always_comb begin
    sum_d  = sum_q;
    fill_d = fill_q;
    if (wr_vld) begin
      sum_d = sum_q + SW'(wr_dat) - SW'(win_q[ptr_q]);
      if (fill_q != FULL) fill_d = fill_q + (AVG_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      avg_vld_q <= wr_vld && (fill_d == FULL);
      if (wr_vld) begin
        win_q[ptr_q] <= wr_dat;
        ptr_q        <= ptr_q + AVG_LOG2'(1);
        sum_q        <= sum_d;
        fill_q       <= fill_d;
        if (fill_d == FULL) avg_q <= sum_d[SW-1:AVG_LOG2];
      end
    end
  end

  always_comb begin
    prox_d = prox_q;
    if (avg_vld_q) begin
      unique case (prox_q)
        FAR:  if (avg_q < NEAR_TH) prox_d = NEAR;
        NEAR: if (avg_q > FAR_TH)  prox_d = FAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prox_q <= FAR;
    else if (clear) prox_q <= FAR;
    else            prox_q <= prox_d;
  end

  assign avg_distance = avg_q;
  assign avg_valid    = avg_vld_q;
  assign near         = (prox_q == NEAR);
  assign no_echo      = no_echo_q;

endmodule
